// File: rtl/load_store_unit_if.sv
// Memory dispatch, result broadcast and byte-wide RAM port of the load/store unit.
// slave is the unit's view; master is the dispatcher/RAM side.
interface load_store_unit_if #(
  parameter int TAG_W = 3
);
  logic [4:0]       memory_op;
  logic [31:0]      memory_value1;
  logic [31:0]      memory_value2;
  logic [31:0]      memory_imm;
  logic [TAG_W-1:0] memory_des;
  logic             memory_busy;
  logic [31:0]      memory_data;
  logic [TAG_W-1:0] memory_des_in;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic [7:0]       mem_dout;
  logic [7:0]       mem_din;

  modport slave (
    input  memory_op, memory_value1, memory_value2, memory_imm, memory_des, mem_din,
    output memory_busy, memory_data, memory_des_in, mem_a, mem_wr, mem_dout
  );

  modport master (
    output memory_op, memory_value1, memory_value2, memory_imm, memory_des, mem_din,
    input  memory_busy, memory_data, memory_des_in, mem_a, mem_wr, mem_dout
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-issue load/store unit: moves 1/2/4 bytes one per cycle over a byte-wide
// little-endian RAM port and broadcasts the result tag for one cycle.
module load_store_unit #(
  parameter int TAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  localparam logic [4:0] OP_LB  = 5'b10010;
  localparam logic [4:0] OP_LH  = 5'b10011;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_LBU = 5'b10101;
  localparam logic [4:0] OP_LHU = 5'b10110;
  localparam logic [4:0] OP_SB  = 5'b10111;
  localparam logic [4:0] OP_SH  = 5'b11000;
  localparam logic [4:0] OP_SW  = 5'b11001;

  state_t           r_state;
  logic [31:0]      r_addr;
  logic [31:0]      r_sdata;
  logic [31:0]      r_result;
  logic [4:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic [2:0]       r_n;
  logic [2:0]       r_cnt;

  logic             w_accept;
  logic             w_isStore;
  logic [31:0]      w_reqAddr;
  logic [2:0]       w_reqN;
  logic [2:0]       w_nextCnt;
  logic [1:0]       w_byteIdx;
  logic [31:0]      w_loadWord;
  logic [31:0]      w_loadResult;

  assign w_accept  = (bus.memory_des != '0) && (bus.memory_op >= OP_LB) && (bus.memory_op <= OP_SW);
  assign w_isStore = (bus.memory_op >= OP_SB);
  assign w_reqAddr = bus.memory_value1 + bus.memory_imm;
  assign w_nextCnt = r_cnt + 3'd1;
  assign w_byteIdx = r_cnt[1:0] - 2'd1;

  // The last byte arrives on the completing edge, so it is merged here rather than registered first.
  always_comb begin
    w_reqN = 3'd4;
    case (bus.memory_op)
      OP_LB, OP_LBU, OP_SB: w_reqN = 3'd1;
      OP_LH, OP_LHU, OP_SH: w_reqN = 3'd2;
      default:              w_reqN = 3'd4;
    endcase

    w_loadWord = r_result;
    if (r_cnt != 3'd0) begin
      w_loadWord[{w_byteIdx, 3'b000} +: 8] = bus.mem_din;
    end

    case (r_op)
      OP_LB:   w_loadResult = {{24{w_loadWord[7]}}, w_loadWord[7:0]};
      OP_LH:   w_loadResult = {{16{w_loadWord[15]}}, w_loadWord[15:0]};
      OP_LBU:  w_loadResult = {24'd0, w_loadWord[7:0]};
      OP_LHU:  w_loadResult = {16'd0, w_loadWord[15:0]};
      default: w_loadResult = w_loadWord;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_addr            <= '0;
      r_sdata           <= '0;
      r_result          <= '0;
      r_op              <= '0;
      r_tag             <= '0;
      r_n               <= '0;
      r_cnt             <= '0;
      bus.memory_busy   <= 1'b0;
      bus.memory_data   <= '0;
      bus.memory_des_in <= '0;
      bus.mem_a         <= '0;
      bus.mem_wr        <= 1'b0;
      bus.mem_dout      <= '0;
    end else begin
      bus.memory_des_in <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr          <= w_reqAddr;
            r_sdata         <= bus.memory_value2;
            r_op            <= bus.memory_op;
            r_tag           <= bus.memory_des;
            r_n             <= w_reqN;
            r_cnt           <= 3'd0;
            r_result        <= '0;
            bus.memory_busy <= 1'b1;
            bus.mem_a       <= w_reqAddr;
            if (w_isStore) begin
              r_state      <= STORE;
              bus.mem_wr   <= 1'b1;
              bus.mem_dout <= bus.memory_value2[7:0];
            end else begin
              r_state      <= LOAD;
              bus.mem_wr   <= 1'b0;
              bus.mem_dout <= '0;
            end
          end
        end

        // Read data lags the address by one cycle, hence byte cnt-1 is captured at count cnt.
        LOAD: begin
          if (r_cnt != 3'd0) begin
            r_result[{w_byteIdx, 3'b000} +: 8] <= bus.mem_din;
          end
          if (r_cnt == r_n) begin
            r_state           <= IDLE;
            r_cnt             <= 3'd0;
            bus.memory_data   <= w_loadResult;
            bus.memory_des_in <= r_tag;
            bus.memory_busy   <= 1'b0;
            bus.mem_a         <= '0;
          end else begin
            r_cnt <= w_nextCnt;
            if (w_nextCnt < r_n) begin
              bus.mem_a <= r_addr + {29'd0, w_nextCnt};
            end else begin
              bus.mem_a <= '0;
            end
          end
        end

        STORE: begin
          if (r_cnt == r_n - 3'd1) begin
            r_state           <= IDLE;
            r_cnt             <= 3'd0;
            bus.memory_data   <= '0;
            bus.memory_des_in <= r_tag;
            bus.memory_busy   <= 1'b0;
            bus.mem_a         <= '0;
            bus.mem_wr        <= 1'b0;
            bus.mem_dout      <= '0;
          end else begin
            r_cnt        <= w_nextCnt;
            bus.mem_a    <= r_addr + {29'd0, w_nextCnt};
            bus.mem_dout <= r_sdata[{w_nextCnt[1:0], 3'b000} +: 8];
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execution unit on the memory side of the reservation station. It accepts one load or store at a time from the memory dispatch port, performs it against a byte-wide, little-endian RAM port, and broadcasts the result on the memory result bus (`memory_data`/`memory_des_in`) that the reservation station snoops. While an operation is in flight it holds `memory_busy` high, which throttles memory dispatch.

## Interface
- `TAG_W`, 3: tag width; tag 0 means "no instruction / no result".
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memory_op` in 5: opcode. LB=10010, LH=10011, LW=10100, LBU=10101, LHU=10110, SB=10111, SH=11000, SW=11001.
- `memory_value1` in 32: base register value.
- `memory_value2` in 32: store data; ignored for loads.
- `memory_imm` in 32: sign-extended offset.
- `memory_des` in TAG_W: issue tag; nonzero = request valid this cycle.
- `memory_busy` out 1: unit occupied; new requests are not accepted.
- `memory_data` out 32: result value (load data; 0 for stores).
- `memory_des_in` out TAG_W: result tag, nonzero for exactly one cycle per completed op.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write byte `mem_dout` at `mem_a` this cycle.
- `mem_dout` out 8: write byte.
- `mem_din` in 8: read byte, valid one cycle after its address is driven with `mem_wr`=0.

## Operation
- States: IDLE, LOAD, STORE.
- Accept: at a rising edge in IDLE with `memory_des`≠0 and `memory_op` in LB..SW, the unit latches:
  - `addr` = `memory_value1` + `memory_imm`, mod 2^32;
  - `sdata` = `memory_value2`, `op`, `tag`;
  - N = 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
  - It sets `cnt`=0 and `memory_busy`=1, then enters LOAD or STORE.
- A request arriving while not IDLE, or carrying an opcode outside LB..SW, is ignored. It is not queued and no broadcast occurs.
- RAM port outputs are driven only from state registers, with no combinational path from inputs.
  - IDLE: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.
  - LOAD: `mem_a`=`addr`+`cnt` (while `cnt`<N), `mem_wr`=0.
  - STORE: `mem_a`=`addr`+`cnt`, `mem_wr`=1, `mem_dout`=`sdata` byte `cnt`.
- LOAD, each edge: if `cnt`≥1, capture `mem_din` into result byte `cnt`−1; then `cnt`++.
  - The edge at `cnt`=N captures the last byte and completes the op.
  - On completion, `memory_data` takes the assembled value: sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - On completion, `memory_des_in`=`tag` and `memory_busy`=0, and the unit returns to IDLE.
- STORE, each edge: `cnt`++. The edge at `cnt`=N−1 completes the op with `memory_data`=0, `memory_des_in`=`tag`, `memory_busy`=0, and a return to IDLE.
- Byte order is little-endian: byte k sits at `addr`+k. Any alignment is legal, and the address wraps mod 2^32.
- `memory_des_in` returns to 0 on the edge after a broadcast. `memory_data` holds its value.

## Timing
- Reset values: `memory_busy`=0, `memory_data`=0, `memory_des_in`=0, `mem_a`=0, `mem_wr`=0, `mem_dout`=0, state IDLE, `cnt`=0.
- Latency is counted from accept edge E0 to the broadcast edge.
  - Loads: E0+N+1, so LB=2, LH=3, LW=5 cycles.
  - Stores: E0+N, so SB=1, SH=2, SW=4 cycles.
- RAM write cycles: exactly N cycles with `mem_wr`=1 per store. Loads never assert `mem_wr`.
- `memory_busy` rises on the accept edge and falls on the broadcast edge.
  - The dispatcher samples `memory_busy` between edges, so it sees busy before it can issue again.
  - The earliest next accept is the edge after the broadcast edge.
- Back-to-back operations: the broadcast cycle of op A and the accept of op B never overlap.
- Reset mid-operation: the in-flight op is aborted and no broadcast occurs. A store may be partially written, and that is accepted. All outputs return to reset values on that edge.
- A request presented in the same cycle as `rst` is dropped.

## Test plan
- LW, value1=0x100, imm=4, tag=3; RAM[0x104..0x107]=78 56 34 12.
  - `mem_a` runs 0x104..0x107.
  - After 5 edges, `memory_data`=0x12345678 and `memory_des_in`=3 for one cycle; busy then falls.
- LB at 0x20 holding 0x80 gives 0xFFFFFF80. LBU at the same address gives 0x00000080. LH at 0x21 (misaligned) over bytes FE FF gives 0xFFFFFFFE.
- SW, value1=0x1FF, imm=1, value2=0xDEADBEEF, tag=5.
  - Writes EF, BE, AD, DE to 0x200..0x203 with `mem_wr`=1 for exactly 4 cycles.
  - Then broadcasts `memory_des_in`=5 with `memory_data`=0.
- Issue SH while an LW is busy: the SH is ignored and no extra RAM access occurs. Reissuing it after the LW broadcast completes it normally.
- Wrap-around: LH at 0xFFFFFFFF reads addresses 0xFFFFFFFF, then 0x00000000.
- Assert `rst` during cycle 2 of an SW: at most 2 bytes are written, there is no broadcast, and all outputs are 0 on the next cycle. An ADD opcode (00000) issued with tag 1 produces nothing.
